// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the byte-serial RV32I instruction fetch unit.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'd0,
    STATE_FETCHING = 2'd1,
    STATE_HOLDING  = 2'd2
  } fetch_state_t;

  localparam int          INSTRUCTION_BYTES          = 4;
  localparam logic [31:0] INSTRUCTION_ALIGNMENT_MASK = 32'hFFFF_FFFC;
  localparam logic [1:0]  LAST_BYTE_INDEX            = 2'(INSTRUCTION_BYTES - 1);
  localparam logic [31:0] PC_INCREMENT               = 32'(INSTRUCTION_BYTES);

  function automatic logic [31:0] align_address(input logic [31:0] address);
    return address & INSTRUCTION_ALIGNMENT_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetches one 32-bit instruction as four little-endian byte reads and hands it
// to decode over valid/ready; owns the program counter and honours redirects.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        memory_request,
  output logic [31:0] memory_address,
  input  logic        memory_ready,
  input  logic [7:0]  memory_data,
  input  logic        redirect,
  input  logic [31:0] redirect_address,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] program_counter
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   byte_index_q, byte_index_d;
  logic [31:0]  instruction_q, instruction_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= STATE_IDLE;
      pc_q          <= RESET_ADDRESS;
      byte_index_q  <= 2'd0;
      instruction_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_index_q  <= byte_index_d;
      instruction_q <= instruction_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    byte_index_d      = byte_index_q;
    instruction_d     = instruction_q;
    memory_request    = 1'b0;
    instruction_valid = 1'b0;

    unique case (state_q)
      STATE_IDLE: begin
        state_d = STATE_FETCHING;
      end
      STATE_FETCHING: begin
        memory_request = 1'b1;
        if (memory_ready) begin
          instruction_d[{byte_index_q, 3'b000} +: 8] = memory_data;
          byte_index_d = byte_index_q + 2'd1;
          if (byte_index_q == LAST_BYTE_INDEX) begin
            state_d = STATE_HOLDING;
          end
        end
      end
      STATE_HOLDING: begin
        instruction_valid = 1'b1;
        if (instruction_ready) begin
          pc_d    = pc_q + PC_INCREMENT;
          state_d = STATE_FETCHING;
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase

    // Redirect overrides everything; a byte accepted this cycle belongs to the
    // abandoned path, so the assembly register keeps its old contents.
    if (redirect) begin
      pc_d          = align_address(redirect_address);
      byte_index_d  = 2'd0;
      state_d       = STATE_FETCHING;
      instruction_d = instruction_q;
    end
  end

  assign memory_address  = pc_q + {30'd0, byte_index_q};
  assign instruction     = instruction_q;
  assign program_counter = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: main unit at address 0 and a second
// unit reset to the top word to exercise program counter wrap and reset.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic        memory_request;
  logic [31:0] memory_address;
  logic        memory_ready;
  logic [7:0]  memory_data;
  logic        redirect;
  logic [31:0] redirect_address;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] program_counter;

  logic        w_reset_n;
  logic        w_memory_request;
  logic [31:0] w_memory_address;
  logic [7:0]  w_memory_data;
  logic        w_instruction_valid;
  logic        w_instruction_ready;
  logic [31:0] w_instruction;
  logic [31:0] w_program_counter;
  logic        w_memory_ready;
  logic        w_redirect;
  logic [31:0] w_redirect_address;

  logic [7:0] mem [0:1023];

  int errors = 0;
  int checks = 0;
  int n;

  instruction_fetch #(.RESET_ADDRESS(32'h0000_0000)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .memory_request    (memory_request),
    .memory_address    (memory_address),
    .memory_ready      (memory_ready),
    .memory_data       (memory_data),
    .redirect          (redirect),
    .redirect_address  (redirect_address),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .instruction       (instruction),
    .program_counter   (program_counter)
  );

  instruction_fetch #(.RESET_ADDRESS(32'hFFFF_FFFC)) dut_wrap (
    .clock             (clock),
    .reset_n           (w_reset_n),
    .memory_request    (w_memory_request),
    .memory_address    (w_memory_address),
    .memory_ready      (w_memory_ready),
    .memory_data       (w_memory_data),
    .redirect          (w_redirect),
    .redirect_address  (w_redirect_address),
    .instruction_valid (w_instruction_valid),
    .instruction_ready (w_instruction_ready),
    .instruction       (w_instruction),
    .program_counter   (w_program_counter)
  );

  assign memory_data   = mem[memory_address[9:0]];
  assign w_memory_data = mem[w_memory_address[9:0]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Ticks until the chosen unit raises instruction_valid; n is cycles taken.
  task automatic wait_valid(input bit wrap_unit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (((wrap_unit ? w_instruction_valid : instruction_valid) !== 1'b1) && cycles < 40);
  endtask

  task automatic put_word(input int base, input logic [31:0] word);
    mem[base]     = word[7:0];
    mem[base + 1] = word[15:8];
    mem[base + 2] = word[23:16];
    mem[base + 3] = word[31:24];
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    put_word(32'h000, 32'h0050_0013);
    put_word(32'h004, 32'h00A0_0093);
    put_word(32'h008, 32'h0020_81B3);
    put_word(32'h040, 32'h0000_0513);
    put_word(32'h044, 32'h40B5_0533);
    put_word(32'h048, 32'h1234_5678);
    put_word(32'h100, 32'h0040_006F);
    put_word(32'h3FC, 32'h0000_0013);

    reset_n = 1'b0;  w_reset_n = 1'b0;
    memory_ready = 1'b1;  w_memory_ready = 1'b1;
    redirect = 1'b0;  redirect_address = 32'h0;
    w_redirect = 1'b0;  w_redirect_address = 32'h0;
    instruction_ready = 1'b0;  w_instruction_ready = 1'b0;
    tick();
    tick();

    chk("reset_request", {31'd0, memory_request}, 32'd0);
    chk("reset_address", memory_address, 32'h0000_0000);
    chk("reset_valid", {31'd0, instruction_valid}, 32'd0);
    chk("reset_instruction", instruction, 32'h0000_0000);
    chk("reset_pc", program_counter, 32'h0000_0000);
    $display("step reset: request=%b address=%h valid=%b", memory_request, memory_address, instruction_valid);

    // First fetch after release, memory always ready.
    reset_n = 1'b1;
    tick();
    chk("first_request", {31'd0, memory_request}, 32'd1);
    chk("first_address", memory_address, 32'h0000_0000);
    wait_valid(1'b0, n);
    chk("first_latency", 32'(n + 1), 32'd5);
    chk("first_instruction", instruction, 32'h0050_0013);
    chk("first_pc", program_counter, 32'h0000_0000);
    $display("step first: cycles=%0d instruction=%h pc=%h", n + 1, instruction, program_counter);

    // Back-to-back with decode always ready.
    instruction_ready = 1'b1;
    tick();
    chk("b2b_address", memory_address, 32'h0000_0004);
    chk("b2b_valid_low", {31'd0, instruction_valid}, 32'd0);
    wait_valid(1'b0, n);
    chk("b2b_latency", 32'(n + 1), 32'd5);
    chk("b2b_instruction", instruction, 32'h00A0_0093);
    chk("b2b_pc", program_counter, 32'h0000_0004);
    $display("step b2b: cycles=%0d instruction=%h pc=%h", n + 1, instruction, program_counter);

    wait_valid(1'b0, n);
    chk("third_latency", 32'(n), 32'd5);
    chk("third_instruction", instruction, 32'h0020_81B3);
    chk("third_pc", program_counter, 32'h0000_0008);
    $display("step third: cycles=%0d instruction=%h pc=%h", n, instruction, program_counter);

    // Redirect coincident with the handshake of the instruction at 8.
    redirect = 1'b1;  redirect_address = 32'h0000_0040;
    tick();
    redirect = 1'b0;  instruction_ready = 1'b0;
    chk("redir_hs_address", memory_address, 32'h0000_0040);
    chk("redir_hs_pc", program_counter, 32'h0000_0040);
    chk("redir_hs_valid", {31'd0, instruction_valid}, 32'd0);
    wait_valid(1'b0, n);
    chk("redir_hs_latency", 32'(n), 32'd4);
    chk("redir_hs_instruction", instruction, 32'h0000_0513);
    $display("step redirect_handshake: address=40 cycles=%0d instruction=%h", n, instruction);

    // Memory stall of three cycles before byte 2.
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    chk("stall_start_address", memory_address, 32'h0000_0044);
    tick();
    tick();
    chk("stall_byte2_address", memory_address, 32'h0000_0046);
    memory_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_hold_address", memory_address, 32'h0000_0046);
      chk("stall_hold_request", {31'd0, memory_request}, 32'd1);
    end
    memory_ready = 1'b1;
    tick();
    chk("stall_valid_early", {31'd0, instruction_valid}, 32'd0);
    tick();
    chk("stall_valid", {31'd0, instruction_valid}, 32'd1);
    chk("stall_instruction", instruction, 32'h40B5_0533);
    chk("stall_pc", program_counter, 32'h0000_0044);
    $display("step stall: instruction=%h pc=%h", instruction, program_counter);

    // Redirect to an unaligned target after two bytes of the next fetch.
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    tick();
    tick();
    chk("redir_mid_address_before", memory_address, 32'h0000_004A);
    redirect = 1'b1;  redirect_address = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("redir_mid_address", memory_address, 32'h0000_0100);
    chk("redir_mid_pc", program_counter, 32'h0000_0100);
    chk("redir_mid_valid", {31'd0, instruction_valid}, 32'd0);
    wait_valid(1'b0, n);
    chk("redir_mid_latency", 32'(n), 32'd4);
    chk("redir_mid_instruction", instruction, 32'h0040_006F);
    $display("step redirect_mid: cycles=%0d instruction=%h pc=%h", n, instruction, program_counter);

    // Wrap unit: top-of-memory fetch, then pc wraps to zero.
    w_reset_n = 1'b1;
    wait_valid(1'b1, n);
    chk("wrap_latency", 32'(n), 32'd5);
    chk("wrap_pc", w_program_counter, 32'hFFFF_FFFC);
    chk("wrap_instruction", w_instruction, 32'h0000_0013);
    w_instruction_ready = 1'b1;
    tick();
    w_instruction_ready = 1'b0;
    chk("wrap_next_address", w_memory_address, 32'h0000_0000);
    chk("wrap_next_pc", w_program_counter, 32'h0000_0000);
    $display("step wrap: pc=%h address=%h", w_program_counter, w_memory_address);

    // Asynchronous reset in the middle of a fetch.
    tick();
    tick();
    chk("midreset_address_before", w_memory_address, 32'h0000_0002);
    w_reset_n = 1'b0;
    #1;
    chk("midreset_request", {31'd0, w_memory_request}, 32'd0);
    chk("midreset_address", w_memory_address, 32'hFFFF_FFFC);
    chk("midreset_valid", {31'd0, w_instruction_valid}, 32'd0);
    chk("midreset_instruction", w_instruction, 32'h0000_0000);
    chk("midreset_pc", w_program_counter, 32'hFFFF_FFFC);
    $display("step midreset: request=%b address=%h instruction=%h", w_memory_request, w_memory_address, w_instruction);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
